multicycle_ctrl: RTL
====================

# multicycle_ctrl

Main control unit for the multicycle ARM processor. It sequences the shared datapath (one memory port, one ALU, one register file) through fetch, decode, execute and writeback states. It holds the architectural NZCV flags and evaluates the instruction condition field, absorbing the role of the single-cycle condition logic. All write enables are issued only for instructions whose condition passes.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- Cond  in  4  instruction[31:28].
- Op  in  2  instruction[27:26].
- Funct  in  6  instruction[25:20]; [5]=I, [4:1]=cmd, [0]=S (or L for memory).
- Rd  in  4  instruction[15:12].
- ALUFlags  in  4  live ALU {N,Z,C,V}.
- PCWrite  out  1  PC register enable.
- IRWrite  out  1  instruction register enable.
- MemWrite  out  1  data memory write.
- RegWrite  out  1  register file write.
- AdrSrc  out  1  0=PC, 1=ALUOut as memory address.
- ALUSrcA  out  1  0=RD1, 1=PC.
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4.
- ALUControl  out  2  00=add, 01=sub, 10=and, 11=orr.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ImmSrc  out  2  equals Op.
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01).
- Flags  out  4  stored {N,Z,C,V}.
- State  out  4  current state encoding, for debug.

## Operation
- States (encoding 0–10): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, EXECF. EXECF is execute for compare, with no writeback.
- Transitions:
  - FETCH→DECODE.
  - DECODE: if CondEx=0 or Op=11 →FETCH. Otherwise Op=01→MEMADR, Op=10→BRANCH.
  - DECODE with Op=00: cmd=1010 (CMP)→EXECF; else Funct[5]=0→EXECR, Funct[5]=1→EXECI.
  - MEMADR: Funct[0]=1→MEMRD, else →MEMWR.
  - MEMRD→MEMWB→FETCH. MEMWR→FETCH.
  - EXECR/EXECI→ALUWB→FETCH.
  - EXECF→FETCH. BRANCH→FETCH.
- Per-state outputs (unlisted enables 0, unlisted selects don't-care):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUControl=dec(cmd).
  - EXECI: same as EXECR but ALUSrcB=01.
  - EXECF: ALUSrcA=0, ALUSrcB=Funct[5]?01:00, ALUControl=01.
  - ALUWB: ResultSrc=00, RegWrite=1, PCWrite=(Rd==15).
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=1.
- dec(cmd): 0100→00, 0010→01, 0000→10, 1100→11; any other cmd→00.
- Flag write:
  - At the edge leaving EXECR/EXECI with S=1, or leaving EXECF (S forced), {N,Z}←ALUFlags[3:2].
  - {C,V}←ALUFlags[1:0] only when ALUControl is add or sub.
- CondEx is evaluated from the stored Flags:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !(C&!Z), GE N==V, LT N!=V, GT !Z&(N==V), LE !GT.
  - AL 1; 1111 →0.
- Condition is checked only in DECODE. Later states never re-check, so a flag update in EXEC does not cancel its own writeback.

## Timing
- Cycles per instruction: DP register/immediate 4, CMP 3, LDR 5, STR 4, B 3, failed condition or Op=11 2.
- Outputs are Moore, decoded from State plus the instruction fields only; there is no path from ALUFlags to any output.
- Reset: State←FETCH, Flags←0000 at the edge.
- While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0; select outputs show FETCH values.
- Reset mid-instruction abandons it; nothing further is written and no flag update occurs.
- The first FETCH is the cycle after reset deasserts.

## Test plan
- Reset: reset=1 for 2 cycles in any state → State=0, Flags=0000, all four enables 0. Release → FETCH asserts PCWrite=1, IRWrite=1.
- Instruction 0xE2888001 (ADD R8,R8,#1, AL, S=0) → FETCH, DECODE, EXECI, ALUWB with ALUSrcB=01 and ALUControl=00. RegWrite=1 only in ALUWB, PCWrite=0, Flags unchanged.
- CMP 0xE3580000 with ALUFlags=0110 → FETCH, DECODE, EXECF, FETCH, ALUControl=01, no RegWrite, Flags=0110 afterwards. Then BEQ (Cond=0000, Op=10) → BRANCH with PCWrite=1.
- BNE with Flags Z=1 → DECODE→FETCH after 2 cycles; PCWrite asserted only in FETCH, MemWrite=RegWrite=0 throughout.
- LDR (Op=01, L=1) → 5 states ending in MEMWB with ResultSrc=01 and RegWrite=1. STR (L=0) → MEMWR with AdrSrc=1 and MemWrite=1 for exactly 1 cycle.
- ADDS with ALUFlags=1010 → Flags=1010. ANDS with ALUFlags=0101 and prior Flags=1010 → Flags=0110 (C,V kept). ADD to Rd=15 → ALUWB asserts PCWrite=1 and RegWrite=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM control FSM: sequences the shared datapath and owns the NZCV flags.
// Moore outputs from state + instruction fields; condition is evaluated once, in DECODE.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_EXECF  = 4'd10
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] flags_q;
  logic       cond_ex;
  logic       is_cmp;
  logic       flag_upd;
  logic [1:0] alu_dec;

  assign is_cmp = (Funct[4:1] == 4'b1010);
  assign State  = state;
  assign Flags  = flags_q;
  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = !z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = !c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = !n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = !v;
      4'b1000: cond_ex = c & !z;
      4'b1001: cond_ex = !(c & !z);
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = !z & (n == v);
      4'b1101: cond_ex = !(!z & (n == v));
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    case (Funct[4:1])
      4'b0100: alu_dec = 2'b00;
      4'b0010: alu_dec = 2'b01;
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      default: alu_dec = 2'b00;
    endcase
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (!cond_ex || Op == 2'b11) state_nxt = S_FETCH;
        else if (Op == 2'b01)        state_nxt = S_MEMADR;
        else if (Op == 2'b10)        state_nxt = S_BRANCH;
        else if (is_cmp)             state_nxt = S_EXECF;
        else if (Funct[5])           state_nxt = S_EXECI;
        else                         state_nxt = S_EXECR;
      end
      S_MEMADR: state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_nxt = S_ALUWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    ResultSrc  = 2'b00;
    case (state)
      S_FETCH: begin
        IRWrite = 1'b1; PCWrite = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB:  begin ResultSrc = 2'b01; RegWrite = 1'b1; end
      S_MEMWR:  begin AdrSrc = 1'b1; MemWrite = 1'b1; end
      S_EXECR:  ALUControl = alu_dec;
      S_EXECI:  begin ALUSrcB = 2'b01; ALUControl = alu_dec; end
      S_EXECF:  begin ALUSrcB = Funct[5] ? 2'b01 : 2'b00; ALUControl = 2'b01; end
      S_ALUWB:  begin RegWrite = 1'b1; PCWrite = (Rd == 4'd15); end
      S_BRANCH: begin ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = 1'b1; end
      default: ;
    endcase
    // Reset suppresses all writes and presents the FETCH selects regardless of state.
    if (reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b1;
      ALUSrcB    = 2'b10;
      ALUControl = 2'b00;
      ResultSrc  = 2'b10;
    end
  end

  assign flag_upd = ((state == S_EXECR || state == S_EXECI) && Funct[0]) || (state == S_EXECF);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      flags_q <= 4'b0000;
    end else begin
      state <= state_nxt;
      if (flag_upd) begin
        flags_q[3:2] <= ALUFlags[3:2];
        // Logic ops leave C and V untouched.
        if (ALUControl == 2'b00 || ALUControl == 2'b01)
          flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

endmodule
